// File: rtl/stream_demux_1x4_if.sv
// Handshake bundle for the 1-to-4 buffered stream demultiplexer.
// master = upstream/downstream environment, slave = the demux itself.
interface stream_demux_1x4_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               rr_mode;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [1:0]         rr_ptr;

  modport master (
    output in_valid, in_data, in_sel,
    output rr_mode, out_ready,
    input  in_ready, out_valid,
    input  out_data, rr_ptr
  );

  modport slave (
    input  in_valid, in_data, in_sel,
    input  rr_mode, out_ready,
    output in_ready, out_valid,
    output out_data, rr_ptr
  );
endinterface

// File: rtl/stream_demux_1x4.sv
// Buffered 1-to-4 stream demux: one small FIFO per lane,
// routing by explicit select or by a round-robin pointer.
module stream_demux_1x4 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  stream_demux_1x4_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] mem_q [4][DEPTH];
  ptr_t       wr_q [4];
  ptr_t       wr_d [4];
  ptr_t       rd_q [4];
  ptr_t       rd_d [4];
  cnt_t       cnt_q [4];
  cnt_t       cnt_d [4];
  logic [1:0] rr_q, rr_d;

  logic [1:0]         dest;
  logic [3:0]         full;
  logic [3:0]         push;
  logic [3:0]         pop;
  logic               rdy;
  logic               acc;
  logic [3:0]         ov;
  logic [4*WIDTH-1:0] od;

  // Lane choice, acceptance and per-lane push/pop strobes.
  always_comb begin
    dest = bus.rr_mode ? rr_q : bus.in_sel;
    full = '0;
    for (int i = 0; i < 4; i++)
      full[i] = (cnt_q[i] == CW'(DEPTH));
    rdy  = !rst && !full[dest];
    acc  = bus.in_valid && rdy;
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      push[i] = acc && (dest == 2'(i));
      pop[i]  = ov[i] && bus.out_ready[i];
    end
  end

  // Read side: head word of each lane, masked when empty.
  always_comb begin
    ov = '0;
    od = '0;
    for (int i = 0; i < 4; i++) begin
      ov[i] = (cnt_q[i] != '0);
      if (ov[i])
        od[i*WIDTH +: WIDTH] = mem_q[i][rd_q[i]];
    end
  end

  // Next-state for pointers, counts and round-robin lane.
  always_comb begin
    rr_d = rr_q;
    for (int i = 0; i < 4; i++) begin
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      cnt_d[i] = cnt_q[i];
      if (push[i])
        wr_d[i] = wr_q[i] + 1'b1;
      if (pop[i])
        rd_d[i] = rd_q[i] + 1'b1;
      if (push[i] && !pop[i])
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (pop[i] && !push[i])
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (acc && bus.rr_mode)
      rr_d = rr_q + 2'd1;
  end

  // Control state; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      for (int i = 0; i < 4; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < 4; i++) begin
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Storage needs no reset: empty lanes are masked on output.
  always_ff @(posedge clk) begin
    if (acc)
      mem_q[dest][wr_q[dest]] <= bus.in_data;
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.rr_ptr    = rr_q;
endmodule
